proc_seq_ctrl: RTL and testbench
================================

Name: proc_seq_ctrl

Overview:
Parametrised multicycle instruction sequencer for the processor, replacing the fixed 5-state cycle with a handshaked and stallable one.
- Drives processor state and the phase strobes: memory READ/WRITE, IR load, register read/write, PC load.
- Waits on a memory-ready handshake, with a timeout that leads to a sticky fault.
- Supports a pipeline-style STALL input and a HALT instruction.
- Optionally skips the MEM phase for non-memory instructions.
- Sits between the control-signal decode logic and the datapath/memory.

Parameters:
DATA_WIDTH, 32, instruction width; opcode = INSTRUCTION[DATA_WIDTH-1:DATA_WIDTH-6]; funct = INSTRUCTION[5:0]
WAIT_MAX, 15, max consecutive not-ready cycles tolerated in FETCH/MEM; 0 disables the timeout
WAIT_W, 4, wait-counter width; must satisfy 2**WAIT_W > WAIT_MAX
HALT_OPCODE, 6'h3f, opcode that stops the sequencer

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
INSTRUCTION  in  DATA_WIDTH  current IR contents (valid from DECODE onward)
MEM_RDY  in  1  memory completes the current access this cycle
STALL  in  1  hold current state at next edge
STATE  out  3  FETCH=0 DECODE=1 EXE=2 MEM=3 WB=4 HALT=5 FAULT=6
READ  out  1  memory read strobe
WRITE  out  1  memory write strobe
IR_LOAD  out  1  load IR from memory data
REG_R  out  1  register file read
REG_W  out  1  register file write
PC_LOAD  out  1  load PC
INSTR_DONE  out  1  one cycle per retired instruction (high in WB)
FAULT  out  1  memory timeout, sticky

Behaviour:
- Reset: while RST=1, STATE=FETCH, wait counter=0, and all strobes plus FAULT are 0, immediately and independent of CLK. FETCH strobes appear once RST falls.
- Outputs are Moore (decoded from the registered state and INSTRUCTION), with no combinational path from MEM_RDY or STALL.
- Edge priority: RST > STALL > normal transition. With STALL=1, state and wait counter hold and strobes stay as in the current state.
- FETCH: READ=1, IR_LOAD=1.
  - MEM_RDY=1 -> DECODE.
  - MEM_RDY=0 -> stay and increment the counter.
- DECODE: REG_R=1.
  - opcode==HALT_OPCODE -> HALT.
  - otherwise -> EXE.
- EXE: no strobes.
  - Memory ops (lw 6'h23, sw 6'h2b, push 6'h1b, pop 6'h1c) -> MEM.
  - Other ops -> MEM or WB, as set by the optional feature.
- MEM:
  - READ=1 for lw/pop; WRITE=1 for sw/push; neither for non-memory ops.
  - Non-memory ops (feature disabled) leave MEM after one cycle regardless of MEM_RDY.
  - Memory ops: MEM_RDY=1 -> WB; MEM_RDY=0 -> stay and increment the counter.
- WB: PC_LOAD=1, INSTR_DONE=1, then -> FETCH.
  - REG_W=1 for: R-type except jr (funct 6'h08); addi 08, muli 1d, andi 0c, ori 0d, lui 0f, slti 0a, lw 23; pop 1c; jal 03.
  - REG_W=0 otherwise.
- Timeout (WAIT_MAX>0): at a not-ready edge in FETCH/MEM where counter==WAIT_MAX, go to FAULT. With WAIT_MAX=15, the state is held for 16 cycles, then FAULT.
- Wait counter: cleared on every state change, saturates at WAIT_MAX, never wraps.
- HALT: all strobes 0; held until RST.
- FAULT: FAULT=1, all other strobes 0; held until RST.
- READ and WRITE are never both 1.
- RST asserted mid-access drops READ/WRITE in the same cycle.

Optional Feature:
PROC_SEQ_MEM_SKIP_EN
- Defined: non-memory instructions go EXE -> WB, giving a 4-cycle instruction with MEM_RDY=1.
- Undefined: every instruction passes through MEM (5-cycle fixed sequence); non-memory ops spend exactly one cycle in MEM with READ=WRITE=0.

Test Plan:
1. add (0x00000020 pattern, funct 20), MEM_RDY=1 -> with macro: states 0,1,2,4,0 over 4 cycles, REG_W=1 and INSTR_DONE=1 only in WB; without macro: 0,1,2,3,4 over 5 cycles.
2. lw (opcode 23), MEM_RDY=0 for 3 MEM cycles then 1 -> MEM lasts 4 cycles with READ=1 throughout, then WB with REG_W=1.
3. sw (opcode 2b) -> WRITE=1 only in MEM, READ=0 there, REG_W=0 in WB.
4. MEM_RDY stuck 0 from reset, WAIT_MAX=15 -> 16 cycles in FETCH, then STATE=6, FAULT=1, persisting 20+ cycles until RST.
5. STALL=1 for 2 edges while in DECODE -> DECODE lasts 3 cycles, REG_R stays 1, then EXE.
6. RST pulsed between edges during an sw MEM cycle -> STATE=0 and WRITE=0 immediately. Later, opcode 3f -> HALT after DECODE, no PC_LOAD, held until reset.

Source files
------------

// File: rtl/proc_seq_ctrl.sv
// proc_seq_ctrl: multicycle instruction sequencer with a memory-ready
// handshake, a wait-timeout that ends in a sticky FAULT state, a STALL hold
// and a HALT instruction.
// Optional build macro PROC_SEQ_MEM_SKIP_EN: when defined, non-memory
// instructions bypass the MEM phase (EXE -> WB).
module proc_seq_ctrl #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          WAIT_MAX    = 15,
    parameter int          WAIT_W      = 4,
    parameter logic [5:0]  HALT_OPCODE = 6'h3f
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] INSTRUCTION,
    input  logic                  MEM_RDY,
    input  logic                  STALL,
    output logic [2:0]            STATE,
    output logic                  READ,
    output logic                  WRITE,
    output logic                  IR_LOAD,
    output logic                  REG_R,
    output logic                  REG_W,
    output logic                  PC_LOAD,
    output logic                  INSTR_DONE,
    output logic                  FAULT
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXE    = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_PUSH  = 6'h1b;
    localparam logic [5:0] OP_POP   = 6'h1c;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_MULI  = 6'h1d;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       op_read;
    logic       op_write;
    logic       op_mem;
    logic       op_reg_w;
    logic       unused_bits;

    assign opcode      = INSTRUCTION[DATA_WIDTH-1 -: 6];
    assign funct       = INSTRUCTION[5:0];
    assign unused_bits = ^INSTRUCTION[DATA_WIDTH-7:6];

    // Classify the current instruction for memory direction and register writeback
    always_comb begin
        op_read  = (opcode == OP_LW) || (opcode == OP_POP);
        op_write = (opcode == OP_SW) || (opcode == OP_PUSH);
        op_mem   = op_read || op_write;
        case (opcode)
            OP_RTYPE: op_reg_w = (funct != FN_JR);
            OP_ADDI, OP_MULI, OP_ANDI, OP_ORI, OP_LUI, OP_SLTI,
            OP_LW, OP_POP, OP_JAL: op_reg_w = 1'b1;
            default:  op_reg_w = 1'b0;
        endcase
    end

    // Next-state and wait-counter logic; STALL freezes both, waits time out to FAULT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!STALL) begin
            case (state_q)
                S_FETCH: begin
                    if (MEM_RDY) begin
                        state_d = S_DECODE;
                    end else if ((WAIT_MAX > 0) && (cnt_q == WAIT_LIM)) begin
                        state_d = S_FAULT;
                    end else if (cnt_q != WAIT_LIM) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    state_d = (opcode == HALT_OPCODE) ? S_HALT : S_EXE;
                end
                S_EXE: begin
`ifdef PROC_SEQ_MEM_SKIP_EN
                    state_d = op_mem ? S_MEM : S_WB;
`else
                    state_d = S_MEM;
`endif
                end
                S_MEM: begin
                    if (!op_mem || MEM_RDY) begin
                        state_d = S_WB;
                    end else if ((WAIT_MAX > 0) && (cnt_q == WAIT_LIM)) begin
                        state_d = S_FAULT;
                    end else if (cnt_q != WAIT_LIM) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WB:    state_d = S_FETCH;
                S_HALT:  state_d = S_HALT;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_FAULT;
            endcase
            if (state_d != state_q) begin
                cnt_d = '0;
            end
        end
    end

    // State and wait-counter registers with asynchronous reset to FETCH
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore strobe decode; reset forces every strobe low without waiting for a clock
    always_comb begin
        READ       = 1'b0;
        WRITE      = 1'b0;
        IR_LOAD    = 1'b0;
        REG_R      = 1'b0;
        REG_W      = 1'b0;
        PC_LOAD    = 1'b0;
        INSTR_DONE = 1'b0;
        FAULT      = 1'b0;
        if (!RST) begin
            case (state_q)
                S_FETCH: begin
                    READ    = 1'b1;
                    IR_LOAD = 1'b1;
                end
                S_DECODE: REG_R = 1'b1;
                S_MEM: begin
                    READ  = op_read;
                    WRITE = op_write;
                end
                S_WB: begin
                    PC_LOAD    = 1'b1;
                    INSTR_DONE = 1'b1;
                    REG_W      = op_reg_w;
                end
                S_FAULT: FAULT = 1'b1;
                default: ;
            endcase
        end
    end

    assign STATE = state_q;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// tb_proc_seq_ctrl: table-driven directed vectors, hand-written corner
// sequences (timeouts, reset mid-access, HALT) and a randomized run against
// a phase-list reference model. Honours PROC_SEQ_MEM_SKIP_EN like the DUT.
module tb_proc_seq_ctrl;

    localparam int WAIT_MAX = 15;

`ifdef PROC_SEQ_MEM_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    // Expected strobe bundles {FAULT,READ,WRITE,IR_LOAD,REG_R,REG_W,PC_LOAD,INSTR_DONE}
    localparam logic [7:0] O_F    = 8'h50;
    localparam logic [7:0] O_D    = 8'h08;
    localparam logic [7:0] O_NONE = 8'h00;
    localparam logic [7:0] O_MRD  = 8'h40;
    localparam logic [7:0] O_MWR  = 8'h20;
    localparam logic [7:0] O_WBR  = 8'h07;
    localparam logic [7:0] O_WB   = 8'h03;
    localparam logic [7:0] O_FLT  = 8'h80;

    localparam logic [31:0] I_ADD  = 32'h0000_0020;
    localparam logic [31:0] I_JR   = 32'h0000_0008;
    localparam logic [31:0] I_LW   = 32'h8C00_0000;
    localparam logic [31:0] I_SW   = 32'hAC00_0000;
    localparam logic [31:0] I_HALT = 32'hFC00_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] INSTRUCTION = '0;
    logic        MEM_RDY = 1'b0;
    logic        STALL = 1'b0;
    logic [2:0]  STATE;
    logic        READ, WRITE, IR_LOAD, REG_R, REG_W, PC_LOAD, INSTR_DONE, FAULT;
    logic [7:0]  outs;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic        rdy;
        logic        stall;
        logic [2:0]  st;
        logic [7:0]  o;
    } vec_t;

    vec_t vecs[$];

    proc_seq_ctrl #(
        .DATA_WIDTH(32), .WAIT_MAX(WAIT_MAX), .WAIT_W(4), .HALT_OPCODE(6'h3f)
    ) dut (
        .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .MEM_RDY(MEM_RDY),
        .STALL(STALL), .STATE(STATE), .READ(READ), .WRITE(WRITE),
        .IR_LOAD(IR_LOAD), .REG_R(REG_R), .REG_W(REG_W), .PC_LOAD(PC_LOAD),
        .INSTR_DONE(INSTR_DONE), .FAULT(FAULT)
    );

    assign outs = {FAULT, READ, WRITE, IR_LOAD, REG_R, REG_W, PC_LOAD, INSTR_DONE};

    // Free-running clock, 10 time-unit period
    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic [31:0] instr, input logic rdy, input logic stall);
        INSTRUCTION = instr;
        MEM_RDY     = rdy;
        STALL       = stall;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] exp_st, input logic [7:0] exp_o);
        checks++;
        if (STATE !== exp_st) begin
            failures++;
            $display("[TB] FAIL %s state: got %0d expected %0d (t=%0t)", name, STATE, exp_st, $time);
        end
        checks++;
        if (outs !== exp_o) begin
            failures++;
            $display("[TB] FAIL %s strobes: got %b expected %b (t=%0t)", name, outs, exp_o, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, check, then move to the next falling edge
    task automatic step(input logic [31:0] instr, input logic rdy, input logic stall,
                        input string name, input logic [2:0] st, input logic [7:0] o);
        applyStimulus(instr, rdy, stall);
        #1 checkOutput(name, st, o);
        @(negedge CLK);
    endtask

    task automatic doReset();
        @(negedge CLK);
        RST = 1'b1;
        applyStimulus('0, 1'b0, 1'b0);
        #1 checkOutput("reset_async", 3'd0, O_NONE);
        @(negedge CLK);
        checkOutput("reset_hold", 3'd0, O_NONE);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic addVec(input logic [31:0] instr, input logic rdy, input logic stall,
                          input logic [2:0] st, input logic [7:0] o);
        vec_t v;
        v.instr = instr; v.rdy = rdy; v.stall = stall; v.st = st; v.o = o;
        vecs.push_back(v);
    endtask

    // Reference model helpers, written from the instruction-level rules
    function automatic bit isMemOp(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        return (op == 6'h23) || (op == 6'h2b) || (op == 6'h1b) || (op == 6'h1c);
    endfunction

    function automatic bit writesReg(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00) return fn != 6'h08;
        return op inside {6'h08, 6'h1d, 6'h0c, 6'h0d, 6'h0f, 6'h0a, 6'h23, 6'h1c, 6'h03};
    endfunction

    function automatic logic [7:0] expOut(input int ph, input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        case (ph)
            0: return O_F;
            1: return O_D;
            3: begin
                if (op == 6'h23 || op == 6'h1c) return O_MRD;
                if (op == 6'h2b || op == 6'h1b) return O_MWR;
                return O_NONE;
            end
            4: return writesReg(ins) ? O_WBR : O_WB;
            6: return O_FLT;
            default: return O_NONE;
        endcase
    endfunction

    function automatic logic [31:0] randInstr();
        logic [5:0]  ops [15] = '{6'h00, 6'h00, 6'h08, 6'h1d, 6'h0c, 6'h0d, 6'h0f,
                                  6'h0a, 6'h23, 6'h2b, 6'h1b, 6'h1c, 6'h03, 6'h04, 6'h02};
        logic [5:0]  fns [5]  = '{6'h20, 6'h22, 6'h24, 6'h08, 6'h2a};
        logic [31:0] r;
        r = $urandom();
        r[31:26] = ops[$urandom_range(14, 0)];
        if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(4, 0)];
        return r;
    endfunction

    // Randomized run: each instruction is a list of phases walked by a pointer
    task automatic randomRun(input int cycles);
        int          ph_list[$];
        int          idx;
        int          waits;
        bit          faulted;
        int          ph;
        logic [31:0] cur;
        logic        rdy;
        logic        stl;
        idx = 0; waits = 0; faulted = 0;
        cur = randInstr();
        ph_list = '{0, 1, 2};
        if (isMemOp(cur) || !SKIP) ph_list.push_back(3);
        ph_list.push_back(4);
        for (int c = 0; c < cycles; c++) begin
            rdy = ($urandom_range(3, 0) != 0);
            stl = ($urandom_range(7, 0) == 0);
            applyStimulus(cur, rdy, stl);
            ph = faulted ? 6 : ph_list[idx];
            #1 checkOutput("random", 3'(ph), expOut(ph, cur));
            @(posedge CLK);
            if (!faulted && !stl) begin
                if ((ph == 0 || (ph == 3 && isMemOp(cur))) && !rdy) begin
                    waits++;
                    if (WAIT_MAX > 0 && waits > WAIT_MAX) faulted = 1;
                end else begin
                    waits = 0;
                    idx++;
                    if (idx == ph_list.size()) begin
                        idx = 0;
                        cur = randInstr();
                        ph_list = '{0, 1, 2};
                        if (isMemOp(cur) || !SKIP) ph_list.push_back(3);
                        ph_list.push_back(4);
                    end
                end
            end
            @(negedge CLK);
        end
    endtask

    // Main test sequence
    initial begin
        // Directed table: add, lw with MEM waits, sw, stalled add, jr
        addVec(I_ADD, 1, 0, 0, O_F);
        addVec(I_ADD, 0, 0, 1, O_D);
        addVec(I_ADD, 0, 0, 2, O_NONE);
        if (!SKIP) addVec(I_ADD, 0, 0, 3, O_NONE);
        addVec(I_ADD, 0, 0, 4, O_WBR);
        addVec(I_LW,  1, 0, 0, O_F);
        addVec(I_LW,  0, 0, 1, O_D);
        addVec(I_LW,  0, 0, 2, O_NONE);
        addVec(I_LW,  0, 0, 3, O_MRD);
        addVec(I_LW,  0, 0, 3, O_MRD);
        addVec(I_LW,  0, 0, 3, O_MRD);
        addVec(I_LW,  1, 0, 3, O_MRD);
        addVec(I_LW,  0, 0, 4, O_WBR);
        addVec(I_SW,  1, 0, 0, O_F);
        addVec(I_SW,  0, 0, 1, O_D);
        addVec(I_SW,  0, 0, 2, O_NONE);
        addVec(I_SW,  1, 0, 3, O_MWR);
        addVec(I_SW,  0, 0, 4, O_WB);
        addVec(I_ADD, 1, 0, 0, O_F);
        addVec(I_ADD, 1, 1, 1, O_D);
        addVec(I_ADD, 1, 1, 1, O_D);
        addVec(I_ADD, 0, 0, 1, O_D);
        addVec(I_ADD, 1, 0, 2, O_NONE);
        if (!SKIP) addVec(I_ADD, 1, 0, 3, O_NONE);
        addVec(I_ADD, 0, 0, 4, O_WBR);
        addVec(I_JR,  1, 0, 0, O_F);
        addVec(I_JR,  0, 0, 1, O_D);
        addVec(I_JR,  0, 0, 2, O_NONE);
        if (!SKIP) addVec(I_JR, 0, 0, 3, O_NONE);
        addVec(I_JR,  0, 0, 4, O_WB);
        addVec(I_JR,  0, 0, 0, O_F);

        doReset();
        foreach (vecs[i]) begin
            step(vecs[i].instr, vecs[i].rdy, vecs[i].stall, $sformatf("vec%0d", i), vecs[i].st, vecs[i].o);
        end

        // FETCH timeout: 16 not-ready cycles, then sticky FAULT
        doReset();
        for (int i = 0; i < 16; i++) step(I_ADD, 0, 0, "fetch_wait", 0, O_F);
        for (int i = 0; i < 22; i++) step(I_ADD, i[0], 0, "fetch_fault", 6, O_FLT);

        // MEM timeout on a load
        doReset();
        step(I_LW, 1, 0, "lw_f", 0, O_F);
        step(I_LW, 0, 0, "lw_d", 1, O_D);
        step(I_LW, 0, 0, "lw_e", 2, O_NONE);
        for (int i = 0; i < 16; i++) step(I_LW, 0, 0, "mem_wait", 3, O_MRD);
        for (int i = 0; i < 4; i++) step(I_LW, 1, 0, "mem_fault", 6, O_FLT);

        // Reset asserted between edges while a store is writing
        doReset();
        step(I_SW, 1, 0, "sw_f", 0, O_F);
        step(I_SW, 0, 0, "sw_d", 1, O_D);
        step(I_SW, 0, 0, "sw_e", 2, O_NONE);
        applyStimulus(I_SW, 0, 0);
        #1 checkOutput("sw_mem", 3, O_MWR);
        #2 RST = 1'b1;
        #1 checkOutput("rst_mid_access", 0, O_NONE);
        @(negedge CLK);
        RST = 1'b0;
        #1 checkOutput("rst_release", 0, O_F);
        @(negedge CLK);

        // HALT: stops after DECODE with no PC load, held until reset
        doReset();
        step(I_HALT, 1, 0, "halt_f", 0, O_F);
        step(I_HALT, 0, 0, "halt_d", 1, O_D);
        for (int i = 0; i < 10; i++) step(I_HALT, i[0], 0, "halt_hold", 5, O_NONE);
        doReset();
        step(I_ADD, 1, 0, "after_halt", 0, O_F);

        // Randomized instructions, handshakes and stalls
        doReset();
        randomRun(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation time limit reached, got no completion expected completion");
        $fatal(1, "[TB] time limit");
    end

endmodule
